// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - two-state cache block fill controller (8 x 16-bit words).
// Optional macro CACHE_FILL_CRITICAL_WORD_FIRST_EN: request/write the missing word first.
module cache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic [15:0]       memory_data,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        word_offset,
  output logic [15:0]       fill_data,
  output logic              write_tag_array
);

  localparam logic [3:0] CNT_MAX = 4'(WORDS_PER_BLOCK);

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [ADDR_W-5:0] base;
  logic [3:0]        req_cnt;
  logic [3:0]        rcv_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic              unused_addr_bits;

`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
  logic [2:0] start_word;

  function automatic logic [2:0] order(input logic [2:0] n);
    return start_word + n;
  endfunction
`else
  function automatic logic [2:0] order(input logic [2:0] n);
    return n;
  endfunction
`endif

  // The byte-within-word and word-within-block bits only matter for word ordering.
  assign unused_addr_bits = ^miss_address[3:0];

  assign fsm_busy         = (state == FILL) || (state == IDLE && miss_detected);
  assign mem_req          = (state == FILL) && (req_cnt < CNT_MAX);
  assign memory_address   = mem_req ? {base, order(req_cnt[2:0]), 1'b0} : last_addr;
  assign write_data_array = (state == FILL) && memory_data_valid;
  assign write_tag_array  = write_data_array && (rcv_cnt == CNT_MAX - 4'd1);
  assign word_offset      = order(rcv_cnt[2:0]);
  assign fill_data        = memory_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      base      <= '0;
      req_cnt   <= '0;
      rcv_cnt   <= '0;
      last_addr <= '0;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
      start_word <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            base    <= miss_address[ADDR_W-1:4];
            req_cnt <= '0;
            rcv_cnt <= '0;
            state   <= FILL;
`ifdef CACHE_FILL_CRITICAL_WORD_FIRST_EN
            start_word <= miss_address[3:1];
`endif
          end
        end
        FILL: begin
          // Requests issue back to back regardless of how beats return.
          if (mem_req) begin
            req_cnt   <= req_cnt + 4'd1;
            last_addr <= memory_address;
          end
          if (memory_data_valid) begin
            if (rcv_cnt < CNT_MAX) rcv_cnt <= rcv_cnt + 4'd1;
            if (rcv_cnt == CNT_MAX - 4'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
